// File: rtl/draw_pkg.sv
// Shared types and constants for the drawing engine.
// Opcodes, FSM states and bus widths.
package draw_pkg;

    localparam int ADDR_W = 20;
    localparam int PIX_W  = 8;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_FILL = 4'd1;
    localparam logic [3:0] OP_PLOT = 4'd2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/draw_addr_gen.sv
// Start address by shift-add (base + x + y*stride), then
// column/row stepping of the pixel address, all modulo 2^20.
module draw_addr_gen
    import draw_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic              start,
    input  logic              step_col,
    input  logic              step_row,
    input  logic [15:0]       x,
    input  logic [15:0]       y,
    input  logic [15:0]       stride,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] address
);

    logic [ADDR_W-1:0] mcand;
    logic [ADDR_W-1:0] acc;
    logic [ADDR_W-1:0] org;
    logic [ADDR_W-1:0] row_addr;
    logic [15:0]       mplier;
    logic [15:0]       pitch;

    // Multiply one stride bit per cycle, then walk the rectangle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand    <= '0;
            acc      <= '0;
            org      <= '0;
            row_addr <= '0;
            mplier   <= '0;
            pitch    <= '0;
            address  <= '0;
        end else if (load) begin
            mcand  <= ADDR_W'(y);
            mplier <= stride;
            pitch  <= stride;
            acc    <= '0;
            org    <= base + ADDR_W'(x);
        end else if (shift) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end else if (start) begin
            row_addr <= org + acc;
            address  <= org + acc;
        end else if (step_row) begin
            row_addr <= row_addr + ADDR_W'(pitch);
            address  <= row_addr + ADDR_W'(pitch);
        end else if (step_col) begin
            address <= address + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/drawing_engine.sv
// Rectangle-fill / pixel-plot engine feeding the frame-store arbiter.
// Optional clipping to H_PIXELS x V_PIXELS with `define DRAW_CLIP_EN.
module drawing_engine
    import draw_pkg::*;
#(
    parameter int H_PIXELS = 640,
    parameter int V_PIXELS = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_req,
    output logic              cmd_ack,
    input  logic [15:0]       command,
    input  logic [15:0]       r0,
    input  logic [15:0]       r1,
    input  logic [15:0]       r2,
    input  logic [15:0]       r3,
    input  logic [15:0]       r4,
    input  logic [15:0]       r5,
    input  logic [15:0]       r6,
    input  logic [15:0]       r7,
    output logic              cmd_busy,
    output logic              de_req,
    input  logic              de_ack,
    output logic [ADDR_W-1:0] de_address,
    output logic [PIX_W-1:0]  de_wdata
);

    state_t      state;
    logic [4:0]  cnt;
    logic [15:0] width;
    logic [15:0] height;
    logic [15:0] col;
    logic [15:0] row;
    logic        empty;

    logic [3:0]  opc;
    logic        is_draw;
    logic        load;
    logic        shift;
    logic        start;
    logic        adv;
    logic        last_col;
    logic        last_row;
    logic        step_col;
    logic        step_row;
    logic        nxt_vis;
    logic        unused_bits;

    assign opc         = command[3:0];
    assign is_draw     = (opc == OP_PLOT) ||
                         (opc == OP_FILL && r2 != 16'd0 && r3 != 16'd0);
    assign unused_bits = ^{command[15:4], r4[15:8], r7[15:4]};

    // Sequencing strobes for the address generator
    always_comb begin
        load     = (state == IDLE) && cmd_req;
        shift    = (state == SETUP) && !cnt[4];
        start    = (state == SETUP) && cnt[4];
        adv      = (state == RUN) && (!de_req || de_ack);
        last_col = (col == width - 16'd1);
        last_row = (row == height - 16'd1);
        step_col = adv && !last_col;
        step_row = adv && last_col && !last_row;
    end

`ifdef DRAW_CLIP_EN
    localparam logic [15:0] H_LIM = 16'(H_PIXELS);
    localparam logic [15:0] V_LIM = 16'(V_PIXELS);

    logic [15:0] org_x;
    logic [15:0] org_y;
    logic [15:0] nc;
    logic [15:0] nr;

    // Rectangle origin kept for screen-coordinate clipping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            org_x <= '0;
            org_y <= '0;
        end else if (load) begin
            org_x <= r0;
            org_y <= r1;
        end
    end

    // Visibility of the pixel about to be presented
    always_comb begin
        nc      = step_col ? col + 16'd1 : 16'd0;
        nr      = step_row ? row + 16'd1 : row;
        nxt_vis = (16'(org_x + nc) < H_LIM) &&
                  (16'(org_y + nr) < V_LIM);
    end
`else
    logic unused_cfg;

    assign nxt_vis    = 1'b1;
    assign unused_cfg = ^{16'(H_PIXELS), 16'(V_PIXELS)};
`endif

    // Command FSM with registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            width    <= '0;
            height   <= '0;
            col      <= '0;
            row      <= '0;
            empty    <= 1'b0;
            cmd_ack  <= 1'b0;
            cmd_busy <= 1'b0;
            de_req   <= 1'b0;
            de_wdata <= '0;
        end else begin
            cmd_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_req) begin
                        width    <= (opc == OP_PLOT) ? 16'd1 : r2;
                        height   <= (opc == OP_PLOT) ? 16'd1 : r3;
                        empty    <= !is_draw;
                        de_wdata <= r4[PIX_W-1:0];
                        cnt      <= '0;
                        col      <= '0;
                        row      <= '0;
                        cmd_ack  <= 1'b1;
                        cmd_busy <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (!cnt[4])
                        cnt <= cnt + 5'd1;
                    if (cnt == 5'd0 && empty) begin
                        state <= DONE;
                    end else if (start) begin
                        de_req <= nxt_vis;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (adv) begin
                        if (last_col && last_row) begin
                            de_req <= 1'b0;
                            state  <= DONE;
                        end else if (last_col) begin
                            col    <= '0;
                            row    <= row + 16'd1;
                            de_req <= nxt_vis;
                        end else begin
                            col    <= col + 16'd1;
                            de_req <= nxt_vis;
                        end
                    end
                end
                DONE: begin
                    de_req   <= 1'b0;
                    cmd_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    draw_addr_gen u_addr (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .start    (start),
        .step_col (step_col),
        .step_row (step_row),
        .x        (r0),
        .y        (r1),
        .stride   (r5),
        .base     ({r7[3:0], r6}),
        .address  (de_address)
    );

endmodule
